ldtu_readout_sched: RTL
=======================

Name: ldtu_readout_sched

Overview:
- Read-side scheduler for the 64-word x 32-bit output buffer filled by the LiteDTU control unit (data words, trailers, fallback words).
- Sequences link alignment after reset or on handshake, then drains the buffer one word per serializer word strobe.
- Inserts idle words when the buffer is empty.
- Tracks buffer occupancy, words lost upstream and words transmitted.

Parameters:
Nbits_32, 32, data word width
bits_ptr, 6, buffer pointer width; occupancy input is bits_ptr+1 bits
AlignLen, 8, number of align words sent per alignment sequence (legal range 1..255)
AlignWord, 32'h5A5A5A5A, alignment pattern
IdleWord, 32'hE0000000, idle filler word
Initial, 32'hF0000000, DATA_out value after reset
Watermark, 7'd49, occupancy at or above which almost_full asserts

Ports:
CLK  in  1  clock
rst  in  1  reset
handshake  in  1  link (re)alignment request, level-sampled
out_ready  in  1  serializer word strobe: one word consumed this cycle
fifo_empty  in  1  buffer empty
fifo_count  in  7  buffer occupancy, 0..64
fifo_rdata  in  32  buffer head word, first-word-fall-through (valid while !fifo_empty)
losing_data  in  1  control unit dropped a word this cycle
fifo_rd_en  out  1  pop head word (combinational)
DATA_out  out  32  word to serializer
out_strobe  out  1  DATA_out updated this cycle (registered)
aligned  out  1  1 while in RUN
almost_full  out  1  registered (fifo_count >= Watermark)
lost_cnt  out  8  saturating count of losing_data cycles
word_cnt  out  16  wrapping count of buffer words transmitted

Behaviour:
- CLK is the only clock. rst is synchronous and active-high.
- Reset (wins over all other inputs):
  - state = ALIGN, align_cnt = 0.
  - DATA_out = Initial; out_strobe, aligned, almost_full = 0.
  - lost_cnt = 0, word_cnt = 0.
  - fifo_rd_en = 0 while rst = 1. Buffer contents are not touched.
- States: ALIGN, RUN. The state register is 1 bit.
- ALIGN state:
  - fifo_rd_en = 0.
  - On each out_ready: DATA_out <= AlignWord, out_strobe <= 1, align_cnt <= align_cnt + 1.
  - On the out_ready that emits word number AlignLen: state -> RUN and align_cnt -> 0.
  - handshake = 1 in ALIGN forces align_cnt -> 0, so the sequence restarts. If out_ready is high in the same cycle, that word is still emitted but is not counted.
- RUN state, on each out_ready:
  - fifo_empty = 0: fifo_rd_en = 1 in the same cycle; DATA_out <= fifo_rdata; word_cnt <= word_cnt + 1 (wraps 65535 -> 0).
  - fifo_empty = 1: fifo_rd_en = 0; DATA_out <= IdleWord.
  - out_strobe <= 1 in both cases.
- RUN state, handshake:
  - handshake = 1 moves to ALIGN at the next edge with align_cnt = 0.
  - If out_ready is also high in that cycle, the RUN word is still served first: pop if non-empty, else idle.
  - Unread buffer words are retained and transmitted after realignment.
- Without out_ready:
  - fifo_rd_en = 0.
  - DATA_out holds its value; out_strobe <= 0.
- fifo_rd_en equals (state == RUN) & out_ready & !fifo_empty & !rst. It is never asserted on an empty buffer.
- Latency: DATA_out and out_strobe change one edge after the out_ready cycle.
- aligned is driven from the registered state: 1 exactly while state == RUN.
- lost_cnt increments on each cycle with losing_data = 1 and saturates at 255. It is independent of state.
- almost_full is registered each cycle from the fifo_count input.
- Occupancy bounds: fifo_count = 64 is the full case, handled normally. fifo_count = 0 with fifo_empty = 0 is an upstream error; the block still follows fifo_empty.

Test Plan:
1. Reset, AlignLen=8, out_ready pulsed every 4 cycles, buffer empty:
   - 8 strobes of 32'h5A5A5A5A, then aligned = 1.
   - Following strobes carry 32'hE0000000.
   - fifo_rd_en never asserted.
2. RUN state, buffer preloaded with 3 words {A, B, C}, out_ready held high:
   - fifo_rd_en high for exactly 3 cycles.
   - DATA_out = A, B, C, then IdleWord.
   - word_cnt = 3.
3. handshake and out_ready asserted together in RUN with 2 words buffered:
   - First word is popped and emitted.
   - Then 8 align words are sent, during which aligned = 0.
   - The second word is emitted after alignment.
4. handshake raised after 5 align words:
   - Alignment restarts; 8 further AlignWord strobes occur before aligned = 1, 13 or more in total.
5. losing_data held high for 300 cycles:
   - lost_cnt = 255 and holds.
   - A synchronous rst returns lost_cnt to 0.
6. fifo_count swept 48 -> 49 -> 48:
   - almost_full = 0, then 1 one cycle later, then 0.
   - Separately, rst asserted mid-RUN: next edge gives DATA_out = 32'hF0000000, state ALIGN, counters 0.

Source files
------------

// File: rtl/ldtu_readout_sched.sv
// Read-side scheduler for the LiteDTU output buffer: link alignment sequence,
// then one buffer word (or idle filler) per serializer word strobe.
module ldtu_readout_sched #(
    parameter int                Nbits_32  = 32,
    parameter int                bits_ptr  = 6,
    parameter int                AlignLen  = 8,
    parameter logic [Nbits_32-1:0] AlignWord = 32'h5A5A5A5A,
    parameter logic [Nbits_32-1:0] IdleWord  = 32'hE0000000,
    parameter logic [Nbits_32-1:0] Initial   = 32'hF0000000,
    parameter logic [bits_ptr:0] Watermark = 7'd49
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                handshake,
    input  logic                out_ready,
    input  logic                fifo_empty,
    input  logic [bits_ptr:0]   fifo_count,
    input  logic [Nbits_32-1:0] fifo_rdata,
    input  logic                losing_data,
    output logic                fifo_rd_en,
    output logic [Nbits_32-1:0] DATA_out,
    output logic                out_strobe,
    output logic                aligned,
    output logic                almost_full,
    output logic [7:0]          lost_cnt,
    output logic [15:0]         word_cnt
);

    typedef enum logic {ALIGN = 1'b0, RUN = 1'b1} state_t;

    localparam logic [7:0] ALIGN_LAST = 8'(AlignLen - 1);

    state_t     state;
    logic [7:0] align_cnt;

    // Pop is same-cycle with the strobe because the buffer is first-word-fall-through.
    assign fifo_rd_en = (state == RUN) & out_ready & ~fifo_empty & ~rst;
    assign aligned    = (state == RUN);

    always_ff @(posedge CLK) begin
        if (rst) begin
            state       <= ALIGN;
            align_cnt   <= '0;
            DATA_out    <= Initial;
            out_strobe  <= 1'b0;
            almost_full <= 1'b0;
            lost_cnt    <= '0;
            word_cnt    <= '0;
        end else begin
            almost_full <= (fifo_count >= Watermark);
            out_strobe  <= out_ready;
            if (losing_data && lost_cnt != 8'hFF)
                lost_cnt <= lost_cnt + 8'd1;

            case (state)
                ALIGN: begin
                    if (out_ready)
                        DATA_out <= AlignWord;
                    // A handshake restarts the sequence; a word emitted alongside it is not counted.
                    if (handshake) begin
                        align_cnt <= '0;
                    end else if (out_ready) begin
                        if (align_cnt == ALIGN_LAST) begin
                            state     <= RUN;
                            align_cnt <= '0;
                        end else begin
                            align_cnt <= align_cnt + 8'd1;
                        end
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (!fifo_empty) begin
                            DATA_out <= fifo_rdata;
                            word_cnt <= word_cnt + 16'd1;
                        end else begin
                            DATA_out <= IdleWord;
                        end
                    end
                    if (handshake) begin
                        state     <= ALIGN;
                        align_cnt <= '0;
                    end
                end
                default: state <= ALIGN;
            endcase
        end
    end

endmodule
